// File: rtl/set_pkg.sv
// Shared definitions for the SET job sequencer: field packing, modes,
// sequencer states and the job/result records carried through the FIFOs.
package set_pkg;
    localparam int COORD_W   = 4;
    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int TAG_W     = 4;
    localparam int CAND_W    = 8;

    // central = {xA, yA, xB, yB, unused}, radius = {rA, rB, unused}
    localparam int XA_LSB = 20;
    localparam int YA_LSB = 16;
    localparam int XB_LSB = 12;
    localparam int YB_LSB = 8;
    localparam int RA_LSB = 8;
    localparam int RB_LSB = 4;

    localparam logic [MODE_W-1:0] MODE_A   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_AND = 2'b01;
    localparam logic [MODE_W-1:0] MODE_XOR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_COOL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
        logic [TAG_W-1:0]     tag;
    } job_t;

    typedef struct packed {
        logic [CAND_W-1:0] candidate;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } res_t;
endpackage

// File: rtl/set_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
// Push when full and pop when empty are ignored.
module set_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic                        full;
    logic                        empty;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/set_job_sequencer.sv
// Feeds buffered jobs to the SET counter one at a time and collects each
// count (or a timeout marker) into a result FIFO.
module set_job_sequencer import set_pkg::*; #(
    parameter int IN_DEPTH    = 4,
    parameter int OUT_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [CENTRAL_W-1:0] job_central,
    input  logic [RADIUS_W-1:0]  job_radius,
    input  logic [MODE_W-1:0]    job_mode,
    input  logic [TAG_W-1:0]     job_tag,
    output logic                 set_en,
    output logic [CENTRAL_W-1:0] set_central,
    output logic [RADIUS_W-1:0]  set_radius,
    output logic [MODE_W-1:0]    set_mode,
    input  logic                 set_busy,
    input  logic                 set_valid,
    input  logic [CAND_W-1:0]    set_candidate,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CAND_W-1:0]    res_candidate,
    output logic [TAG_W-1:0]     res_tag,
    output logic                 res_err
);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int ICNT_W = $clog2(IN_DEPTH) + 1;
    localparam int OCNT_W = $clog2(OUT_DEPTH) + 1;

    job_t              job_in;
    job_t              job_head;
    res_t              res_in;
    res_t              res_head;
    logic [ICNT_W-1:0] in_count;
    logic [OCNT_W-1:0] out_count;
    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [TAG_W-1:0]  tag_q;
    logic              reserved;
    logic              job_push;
    logic              job_pop;
    logic              res_push;
    logic              res_pop;
    logic              slot_free;
    logic              timed_out;

    assign job_ready = (in_count != ICNT_W'(IN_DEPTH));
    assign job_push  = job_valid && job_ready;
    assign job_in    = '{central: job_central, radius: job_radius, mode: job_mode, tag: job_tag};

    assign res_valid     = (out_count != '0);
    assign res_pop       = res_valid && res_ready;
    assign res_candidate = res_head.candidate;
    assign res_tag       = res_head.tag;
    assign res_err       = res_head.err;

    // A slot counts as taken from issue until the result is written, so the
    // write in WAIT can never find the result FIFO full.
    assign slot_free = (out_count + OCNT_W'(reserved)) < OCNT_W'(OUT_DEPTH);
    assign job_pop   = (state == ST_IDLE) && (in_count != '0) && slot_free;
    assign timed_out = (timer == TMR_W'(TIMEOUT_CYC));
    assign res_push  = (state == ST_WAIT) && (set_valid || timed_out);

    // A real count wins over a timeout landing in the same cycle.
    always_comb begin
        res_in     = '0;
        res_in.tag = tag_q;
        if (set_valid)
            res_in.candidate = set_candidate;
        else
            res_in.err = 1'b1;
    end

    set_sync_fifo #(.WIDTH($bits(job_t)), .DEPTH(IN_DEPTH)) u_job_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (job_push),
        .wr_data (job_in),
        .pop     (job_pop),
        .rd_data (job_head),
        .count   (in_count)
    );

    set_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(OUT_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (res_push),
        .wr_data (res_in),
        .pop     (res_pop),
        .rd_data (res_head),
        .count   (out_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            set_en      <= 1'b0;
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            tag_q       <= '0;
            timer       <= '0;
            reserved    <= 1'b0;
        end else begin
            set_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (job_pop) begin
                        set_central <= job_head.central;
                        set_radius  <= job_head.radius;
                        set_mode    <= job_head.mode;
                        tag_q       <= job_head.tag;
                        reserved    <= 1'b1;
                        set_en      <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!timed_out)
                        timer <= timer + 1'b1;
                    if (res_push) begin
                        reserved <= 1'b0;
                        state    <= ST_COOL;
                    end
                end
                // en stays low here so SET can drop busy/valid/candidate.
                ST_COOL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    en_while_busy: assert property (@(posedge clk) disable iff (rst) set_en |-> !set_busy);
endmodule
